// File: rtl/tl_pkg.sv
// Shared TileLink field widths and packed beat layouts for the A and D channels.
package tl_pkg;

    localparam int TL_OPCODE_W = 3;
    localparam int TL_SIZE_W   = 3;
    localparam int TL_SOURCE_W = 7;
    localparam int TL_ADDR_W   = 32;
    localparam int TL_DATA_W   = 64;
    localparam int TL_MASK_W   = 8;
    localparam int TL_SINK_W   = 3;

    typedef struct packed {
        logic [TL_OPCODE_W-1:0] opcode;
        logic [2:0]             param;
        logic [TL_SIZE_W-1:0]   size;
        logic [TL_SOURCE_W-1:0] source;
        logic [TL_ADDR_W-1:0]   address;
        logic [TL_MASK_W-1:0]   mask;
        logic [TL_DATA_W-1:0]   data;
        logic                   corrupt;
    } a_beat_t;

    typedef struct packed {
        logic [TL_OPCODE_W-1:0] opcode;
        logic [1:0]             param;
        logic [TL_SIZE_W-1:0]   size;
        logic [TL_SOURCE_W-1:0] source;
        logic [TL_SINK_W-1:0]   sink;
        logic                   denied;
        logic [TL_DATA_W-1:0]   data;
        logic                   corrupt;
    } d_beat_t;

endpackage

// File: rtl/tl_queue.sv
// DEPTH-entry registered FIFO with one cycle of latency and no empty bypass.
// TL_BUFFER_OCCUPANCY_EN adds a count output exposing current occupancy.
module tl_queue #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enq_valid,
    output logic              enq_ready,
    input  logic [DATA_W-1:0] enq_bits,
    output logic              deq_valid,
    input  logic              deq_ready,
    output logic [DATA_W-1:0] deq_bits
`ifdef TL_BUFFER_OCCUPANCY_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] count_o
`endif
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              enq_fire;
    logic              deq_fire;

    // Ready depends on registered count only, so a full queue refuses even when draining.
    assign enq_ready = (count != CNT_W'(DEPTH));
    assign deq_valid = (count != '0);
    assign deq_bits  = mem[rd_ptr];
    assign enq_fire  = enq_valid && enq_ready;
    assign deq_fire  = deq_valid && deq_ready;

`ifdef TL_BUFFER_OCCUPANCY_EN
    assign count_o = count;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq_fire)
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            if (deq_fire)
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            if (enq_fire && !deq_fire)
                count <= count + CNT_W'(1);
            else if (deq_fire && !enq_fire)
                count <= count - CNT_W'(1);
        end
    end

    // Storage carries data only; stale entries are unreachable once pointers clear.
    always_ff @(posedge clock) begin
        if (enq_fire)
            mem[wr_ptr] <= enq_bits;
    end

endmodule

// File: rtl/tl_buffer_ad.sv
// TileLink buffer: A and D channels queued through tl_queue, B/C/E wired straight through.
// TL_BUFFER_OCCUPANCY_EN adds a_count/d_count occupancy outputs.
module tl_buffer_ad
    import tl_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    // A upstream
    input  logic                   auto_in_a_valid,
    output logic                   auto_in_a_ready,
    input  logic [TL_OPCODE_W-1:0] auto_in_a_bits_opcode,
    input  logic [2:0]             auto_in_a_bits_param,
    input  logic [TL_SIZE_W-1:0]   auto_in_a_bits_size,
    input  logic [TL_SOURCE_W-1:0] auto_in_a_bits_source,
    input  logic [TL_ADDR_W-1:0]   auto_in_a_bits_address,
    input  logic [TL_MASK_W-1:0]   auto_in_a_bits_mask,
    input  logic [TL_DATA_W-1:0]   auto_in_a_bits_data,
    input  logic                   auto_in_a_bits_corrupt,
    // A downstream
    output logic                   auto_out_a_valid,
    input  logic                   auto_out_a_ready,
    output logic [TL_OPCODE_W-1:0] auto_out_a_bits_opcode,
    output logic [2:0]             auto_out_a_bits_param,
    output logic [TL_SIZE_W-1:0]   auto_out_a_bits_size,
    output logic [TL_SOURCE_W-1:0] auto_out_a_bits_source,
    output logic [TL_ADDR_W-1:0]   auto_out_a_bits_address,
    output logic [TL_MASK_W-1:0]   auto_out_a_bits_mask,
    output logic [TL_DATA_W-1:0]   auto_out_a_bits_data,
    output logic                   auto_out_a_bits_corrupt,
    // B upstream / downstream
    output logic                   auto_in_b_valid,
    input  logic                   auto_in_b_ready,
    output logic [1:0]             auto_in_b_bits_param,
    output logic [TL_SOURCE_W-1:0] auto_in_b_bits_source,
    output logic [TL_ADDR_W-1:0]   auto_in_b_bits_address,
    input  logic                   auto_out_b_valid,
    output logic                   auto_out_b_ready,
    input  logic [1:0]             auto_out_b_bits_param,
    input  logic [TL_SOURCE_W-1:0] auto_out_b_bits_source,
    input  logic [TL_ADDR_W-1:0]   auto_out_b_bits_address,
    // C upstream / downstream
    input  logic                   auto_in_c_valid,
    output logic                   auto_in_c_ready,
    input  logic [TL_OPCODE_W-1:0] auto_in_c_bits_opcode,
    input  logic [2:0]             auto_in_c_bits_param,
    input  logic [TL_SIZE_W-1:0]   auto_in_c_bits_size,
    input  logic [TL_SOURCE_W-1:0] auto_in_c_bits_source,
    input  logic [TL_ADDR_W-1:0]   auto_in_c_bits_address,
    input  logic [TL_DATA_W-1:0]   auto_in_c_bits_data,
    input  logic                   auto_in_c_bits_corrupt,
    output logic                   auto_out_c_valid,
    input  logic                   auto_out_c_ready,
    output logic [TL_OPCODE_W-1:0] auto_out_c_bits_opcode,
    output logic [2:0]             auto_out_c_bits_param,
    output logic [TL_SIZE_W-1:0]   auto_out_c_bits_size,
    output logic [TL_SOURCE_W-1:0] auto_out_c_bits_source,
    output logic [TL_ADDR_W-1:0]   auto_out_c_bits_address,
    output logic [TL_DATA_W-1:0]   auto_out_c_bits_data,
    output logic                   auto_out_c_bits_corrupt,
    // D downstream
    input  logic                   auto_out_d_valid,
    output logic                   auto_out_d_ready,
    input  logic [TL_OPCODE_W-1:0] auto_out_d_bits_opcode,
    input  logic [1:0]             auto_out_d_bits_param,
    input  logic [TL_SIZE_W-1:0]   auto_out_d_bits_size,
    input  logic [TL_SOURCE_W-1:0] auto_out_d_bits_source,
    input  logic [TL_SINK_W-1:0]   auto_out_d_bits_sink,
    input  logic                   auto_out_d_bits_denied,
    input  logic [TL_DATA_W-1:0]   auto_out_d_bits_data,
    input  logic                   auto_out_d_bits_corrupt,
    // D upstream
    output logic                   auto_in_d_valid,
    input  logic                   auto_in_d_ready,
    output logic [TL_OPCODE_W-1:0] auto_in_d_bits_opcode,
    output logic [1:0]             auto_in_d_bits_param,
    output logic [TL_SIZE_W-1:0]   auto_in_d_bits_size,
    output logic [TL_SOURCE_W-1:0] auto_in_d_bits_source,
    output logic [TL_SINK_W-1:0]   auto_in_d_bits_sink,
    output logic                   auto_in_d_bits_denied,
    output logic [TL_DATA_W-1:0]   auto_in_d_bits_data,
    output logic                   auto_in_d_bits_corrupt,
    // E upstream / downstream
    input  logic                   auto_in_e_valid,
    output logic                   auto_in_e_ready,
    input  logic [TL_SINK_W-1:0]   auto_in_e_bits_sink,
    output logic                   auto_out_e_valid,
    input  logic                   auto_out_e_ready,
    output logic [TL_SINK_W-1:0]   auto_out_e_bits_sink
`ifdef TL_BUFFER_OCCUPANCY_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] a_count,
    output logic [$clog2(DEPTH+1)-1:0] d_count
`endif
);

    a_beat_t a_enq;
    a_beat_t a_deq;
    d_beat_t d_enq;
    d_beat_t d_deq;

    assign a_enq = '{opcode:  auto_in_a_bits_opcode,  param: auto_in_a_bits_param,
                     size:    auto_in_a_bits_size,    source: auto_in_a_bits_source,
                     address: auto_in_a_bits_address, mask: auto_in_a_bits_mask,
                     data:    auto_in_a_bits_data,    corrupt: auto_in_a_bits_corrupt};

    assign {auto_out_a_bits_opcode, auto_out_a_bits_param, auto_out_a_bits_size,
            auto_out_a_bits_source, auto_out_a_bits_address, auto_out_a_bits_mask,
            auto_out_a_bits_data, auto_out_a_bits_corrupt} = a_deq;

    assign d_enq = '{opcode: auto_out_d_bits_opcode, param: auto_out_d_bits_param,
                     size:   auto_out_d_bits_size,   source: auto_out_d_bits_source,
                     sink:   auto_out_d_bits_sink,   denied: auto_out_d_bits_denied,
                     data:   auto_out_d_bits_data,   corrupt: auto_out_d_bits_corrupt};

    assign {auto_in_d_bits_opcode, auto_in_d_bits_param, auto_in_d_bits_size,
            auto_in_d_bits_source, auto_in_d_bits_sink, auto_in_d_bits_denied,
            auto_in_d_bits_data, auto_in_d_bits_corrupt} = d_deq;

    tl_queue #(.DATA_W($bits(a_beat_t)), .DEPTH(DEPTH)) u_a_queue (
        .clock     (clock),
        .reset     (reset),
        .enq_valid (auto_in_a_valid),
        .enq_ready (auto_in_a_ready),
        .enq_bits  (a_enq),
        .deq_valid (auto_out_a_valid),
        .deq_ready (auto_out_a_ready),
        .deq_bits  (a_deq)
`ifdef TL_BUFFER_OCCUPANCY_EN
        ,
        .count_o   (a_count)
`endif
    );

    tl_queue #(.DATA_W($bits(d_beat_t)), .DEPTH(DEPTH)) u_d_queue (
        .clock     (clock),
        .reset     (reset),
        .enq_valid (auto_out_d_valid),
        .enq_ready (auto_out_d_ready),
        .enq_bits  (d_enq),
        .deq_valid (auto_in_d_valid),
        .deq_ready (auto_in_d_ready),
        .deq_bits  (d_deq)
`ifdef TL_BUFFER_OCCUPANCY_EN
        ,
        .count_o   (d_count)
`endif
    );

    // B, C and E carry no buffering.
    assign auto_in_b_valid        = auto_out_b_valid;
    assign auto_out_b_ready       = auto_in_b_ready;
    assign auto_in_b_bits_param   = auto_out_b_bits_param;
    assign auto_in_b_bits_source  = auto_out_b_bits_source;
    assign auto_in_b_bits_address = auto_out_b_bits_address;

    assign auto_out_c_valid        = auto_in_c_valid;
    assign auto_in_c_ready         = auto_out_c_ready;
    assign auto_out_c_bits_opcode  = auto_in_c_bits_opcode;
    assign auto_out_c_bits_param   = auto_in_c_bits_param;
    assign auto_out_c_bits_size    = auto_in_c_bits_size;
    assign auto_out_c_bits_source  = auto_in_c_bits_source;
    assign auto_out_c_bits_address = auto_in_c_bits_address;
    assign auto_out_c_bits_data    = auto_in_c_bits_data;
    assign auto_out_c_bits_corrupt = auto_in_c_bits_corrupt;

    assign auto_out_e_valid     = auto_in_e_valid;
    assign auto_in_e_ready      = auto_out_e_ready;
    assign auto_out_e_bits_sink = auto_in_e_bits_sink;

endmodule

// File: tb/tb_tl_buffer_ad.sv
// Bench for tl_buffer_ad: queue-based reference model checked every cycle plus directed scenarios.
module tb_tl_buffer_ad;

    localparam int DEPTH = 2;
    localparam int CW = $clog2(DEPTH + 1);

    logic clock, reset;
    logic in_a_valid, in_a_ready, in_a_corrupt;
    logic [2:0] in_a_opcode, in_a_param, in_a_size;
    logic [6:0] in_a_source; logic [31:0] in_a_address; logic [7:0] in_a_mask; logic [63:0] in_a_data;
    logic out_a_valid, out_a_ready, out_a_corrupt;
    logic [2:0] out_a_opcode, out_a_param, out_a_size;
    logic [6:0] out_a_source; logic [31:0] out_a_address; logic [7:0] out_a_mask; logic [63:0] out_a_data;
    logic in_b_valid, in_b_ready, out_b_valid, out_b_ready;
    logic [1:0] in_b_param, out_b_param; logic [6:0] in_b_source, out_b_source;
    logic [31:0] in_b_address, out_b_address;
    logic in_c_valid, in_c_ready, in_c_corrupt, out_c_valid, out_c_ready, out_c_corrupt;
    logic [2:0] in_c_opcode, in_c_param, in_c_size, out_c_opcode, out_c_param, out_c_size;
    logic [6:0] in_c_source, out_c_source; logic [31:0] in_c_address, out_c_address;
    logic [63:0] in_c_data, out_c_data;
    logic out_d_valid, out_d_ready, out_d_denied, out_d_corrupt;
    logic [2:0] out_d_opcode, out_d_size, out_d_sink; logic [1:0] out_d_param;
    logic [6:0] out_d_source; logic [63:0] out_d_data;
    logic in_d_valid, in_d_ready, in_d_denied, in_d_corrupt;
    logic [2:0] in_d_opcode, in_d_size, in_d_sink; logic [1:0] in_d_param;
    logic [6:0] in_d_source; logic [63:0] in_d_data;
    logic in_e_valid, in_e_ready, out_e_valid, out_e_ready;
    logic [2:0] in_e_sink, out_e_sink;
`ifdef TL_BUFFER_OCCUPANCY_EN
    logic [CW-1:0] a_count, d_count;
`endif

    int checks = 0;
    int errors = 0;

    tl_buffer_ad #(.DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .auto_in_a_valid(in_a_valid), .auto_in_a_ready(in_a_ready),
        .auto_in_a_bits_opcode(in_a_opcode), .auto_in_a_bits_param(in_a_param),
        .auto_in_a_bits_size(in_a_size), .auto_in_a_bits_source(in_a_source),
        .auto_in_a_bits_address(in_a_address), .auto_in_a_bits_mask(in_a_mask),
        .auto_in_a_bits_data(in_a_data), .auto_in_a_bits_corrupt(in_a_corrupt),
        .auto_out_a_valid(out_a_valid), .auto_out_a_ready(out_a_ready),
        .auto_out_a_bits_opcode(out_a_opcode), .auto_out_a_bits_param(out_a_param),
        .auto_out_a_bits_size(out_a_size), .auto_out_a_bits_source(out_a_source),
        .auto_out_a_bits_address(out_a_address), .auto_out_a_bits_mask(out_a_mask),
        .auto_out_a_bits_data(out_a_data), .auto_out_a_bits_corrupt(out_a_corrupt),
        .auto_in_b_valid(in_b_valid), .auto_in_b_ready(in_b_ready),
        .auto_in_b_bits_param(in_b_param), .auto_in_b_bits_source(in_b_source),
        .auto_in_b_bits_address(in_b_address),
        .auto_out_b_valid(out_b_valid), .auto_out_b_ready(out_b_ready),
        .auto_out_b_bits_param(out_b_param), .auto_out_b_bits_source(out_b_source),
        .auto_out_b_bits_address(out_b_address),
        .auto_in_c_valid(in_c_valid), .auto_in_c_ready(in_c_ready),
        .auto_in_c_bits_opcode(in_c_opcode), .auto_in_c_bits_param(in_c_param),
        .auto_in_c_bits_size(in_c_size), .auto_in_c_bits_source(in_c_source),
        .auto_in_c_bits_address(in_c_address), .auto_in_c_bits_data(in_c_data),
        .auto_in_c_bits_corrupt(in_c_corrupt),
        .auto_out_c_valid(out_c_valid), .auto_out_c_ready(out_c_ready),
        .auto_out_c_bits_opcode(out_c_opcode), .auto_out_c_bits_param(out_c_param),
        .auto_out_c_bits_size(out_c_size), .auto_out_c_bits_source(out_c_source),
        .auto_out_c_bits_address(out_c_address), .auto_out_c_bits_data(out_c_data),
        .auto_out_c_bits_corrupt(out_c_corrupt),
        .auto_out_d_valid(out_d_valid), .auto_out_d_ready(out_d_ready),
        .auto_out_d_bits_opcode(out_d_opcode), .auto_out_d_bits_param(out_d_param),
        .auto_out_d_bits_size(out_d_size), .auto_out_d_bits_source(out_d_source),
        .auto_out_d_bits_sink(out_d_sink), .auto_out_d_bits_denied(out_d_denied),
        .auto_out_d_bits_data(out_d_data), .auto_out_d_bits_corrupt(out_d_corrupt),
        .auto_in_d_valid(in_d_valid), .auto_in_d_ready(in_d_ready),
        .auto_in_d_bits_opcode(in_d_opcode), .auto_in_d_bits_param(in_d_param),
        .auto_in_d_bits_size(in_d_size), .auto_in_d_bits_source(in_d_source),
        .auto_in_d_bits_sink(in_d_sink), .auto_in_d_bits_denied(in_d_denied),
        .auto_in_d_bits_data(in_d_data), .auto_in_d_bits_corrupt(in_d_corrupt),
        .auto_in_e_valid(in_e_valid), .auto_in_e_ready(in_e_ready),
        .auto_in_e_bits_sink(in_e_sink),
        .auto_out_e_valid(out_e_valid), .auto_out_e_ready(out_e_ready),
        .auto_out_e_bits_sink(out_e_sink)
`ifdef TL_BUFFER_OCCUPANCY_EN
        ,
        .a_count(a_count), .d_count(d_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
        end
    endtask

    function automatic logic [120:0] a_in_vec();
        return {in_a_opcode, in_a_param, in_a_size, in_a_source, in_a_address, in_a_mask, in_a_data, in_a_corrupt};
    endfunction
    function automatic logic [120:0] a_out_vec();
        return {out_a_opcode, out_a_param, out_a_size, out_a_source, out_a_address, out_a_mask, out_a_data, out_a_corrupt};
    endfunction
    function automatic logic [83:0] d_in_vec();
        return {out_d_opcode, out_d_param, out_d_size, out_d_source, out_d_sink, out_d_denied, out_d_data, out_d_corrupt};
    endfunction
    function automatic logic [83:0] d_out_vec();
        return {in_d_opcode, in_d_param, in_d_size, in_d_source, in_d_sink, in_d_denied, in_d_data, in_d_corrupt};
    endfunction

    // Reference model: each channel is a bounded queue; acceptance uses occupancy before the edge.
    logic [120:0] aq[$];
    logic [83:0]  dq[$];

    always @(posedge clock or negedge reset) begin
        bit a_enq, a_deq, d_enq, d_deq;
        if (!reset) begin
            aq.delete();
            dq.delete();
        end else begin
            a_enq = in_a_valid && (aq.size() < DEPTH);
            a_deq = out_a_ready && (aq.size() > 0);
            d_enq = out_d_valid && (dq.size() < DEPTH);
            d_deq = in_d_ready && (dq.size() > 0);
            if (a_deq) void'(aq.pop_front());
            if (a_enq) aq.push_back(a_in_vec());
            if (d_deq) void'(dq.pop_front());
            if (d_enq) dq.push_back(d_in_vec());
        end
    end

    always @(negedge clock) begin
        chk("a_valid", out_a_valid, aq.size() != 0);
        chk("a_ready", in_a_ready, aq.size() != DEPTH);
        if (aq.size() != 0) chk("a_bits", a_out_vec(), aq[0]);
        chk("d_valid", in_d_valid, dq.size() != 0);
        chk("d_ready", out_d_ready, dq.size() != DEPTH);
        if (dq.size() != 0) chk("d_bits", d_out_vec(), dq[0]);
`ifdef TL_BUFFER_OCCUPANCY_EN
        chk("a_count", a_count, aq.size());
        chk("d_count", d_count, dq.size());
`endif
        chk("b_pass", {in_b_valid, out_b_ready, in_b_param, in_b_source, in_b_address},
                      {out_b_valid, in_b_ready, out_b_param, out_b_source, out_b_address});
        chk("c_pass", {out_c_valid, in_c_ready, out_c_opcode, out_c_param, out_c_size, out_c_source, out_c_address, out_c_corrupt},
                      {in_c_valid, out_c_ready, in_c_opcode, in_c_param, in_c_size, in_c_source, in_c_address, in_c_corrupt});
        chk("c_data", out_c_data, in_c_data);
        chk("e_pass", {out_e_valid, in_e_ready, out_e_sink}, {in_e_valid, out_e_ready, in_e_sink});
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        {in_a_valid, in_a_opcode, in_a_param, in_a_size, in_a_source, in_a_address, in_a_mask, in_a_data, in_a_corrupt} = '0;
        {out_d_valid, out_d_opcode, out_d_param, out_d_size, out_d_source, out_d_sink, out_d_denied, out_d_data, out_d_corrupt} = '0;
        {out_b_valid, out_b_param, out_b_source, out_b_address, in_b_ready} = '0;
        {in_c_valid, in_c_opcode, in_c_param, in_c_size, in_c_source, in_c_address, in_c_data, in_c_corrupt, out_c_ready} = '0;
        {in_e_valid, in_e_sink, out_e_ready} = '0;
        out_a_ready = 1'b0;
        in_d_ready  = 1'b1;

        // Reset state
        step(); step();
        chk("rst_a_valid", out_a_valid, 1'b0);
        chk("rst_d_valid", in_d_valid, 1'b0);
        reset = 1'b1;
        #1;
        chk("rst_a_ready", in_a_ready, 1'b1);
        chk("rst_d_ready", out_d_ready, 1'b1);
`ifdef TL_BUFFER_OCCUPANCY_EN
        chk("rst_a_count", a_count, 0);
`endif

        // Single A beat: one cycle latency, bits verbatim, no bypass
        in_a_valid = 1'b1; in_a_opcode = 3'd4; in_a_source = 7'h05;
        in_a_address = 32'h8000_0000; in_a_mask = 8'hff; in_a_data = 64'h1234_5678_9abc_def0;
        #1;
        chk("lat_no_bypass", out_a_valid, 1'b0);
        step();
        in_a_valid = 1'b0;
        chk("lat_valid", out_a_valid, 1'b1);
        chk("lat_source", out_a_source, 7'h05);
        chk("lat_address", out_a_address, 32'h8000_0000);
        chk("lat_data", out_a_data, 64'h1234_5678_9abc_def0);
        out_a_ready = 1'b1;
        step();
        chk("lat_drained", out_a_valid, 1'b0);

        // Backpressure: three beats into a two-deep queue, then full-queue deq/enq collision
        out_a_ready = 1'b0;
        in_a_valid = 1'b1; in_a_data = 64'd1; in_a_source = 7'd1;
        chk("bp_ready0", in_a_ready, 1'b1);
        step();
`ifdef TL_BUFFER_OCCUPANCY_EN
        chk("bp_count1", a_count, 1);
`endif
        in_a_data = 64'd2; in_a_source = 7'd2;
        step();
        chk("bp_full_ready", in_a_ready, 1'b0);
        chk("bp_head1", out_a_data, 64'd1);
`ifdef TL_BUFFER_OCCUPANCY_EN
        chk("bp_count2", a_count, 2);
`endif
        in_a_data = 64'd3; in_a_source = 7'd3;
        step();
        chk("bp_stall_ready", in_a_ready, 1'b0);
        chk("bp_stall_head", out_a_data, 64'd1);
        out_a_ready = 1'b1;
        step();
        chk("full_deq_head2", out_a_data, 64'd2);
        chk("full_enq_refused_ready", in_a_ready, 1'b1);
`ifdef TL_BUFFER_OCCUPANCY_EN
        chk("full_count1", a_count, 1);
`endif
        step();
        in_a_valid = 1'b0;
        chk("order_head3", out_a_data, 64'd3);
        chk("order_src3", out_a_source, 7'd3);
        step();
        chk("order_empty", out_a_valid, 1'b0);
`ifdef TL_BUFFER_OCCUPANCY_EN
        chk("bp_count0", a_count, 0);
`endif

        // D streaming: 16 beats in 17 cycles with no bubbles
        in_d_ready = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            out_d_valid = (i < 16);
            out_d_data = 64'(i);
            out_d_source = 7'(i);
            chk("d_stream_enq_ready", out_d_ready, 1'b1);
            if (i >= 1) begin
                chk("d_stream_valid", in_d_valid, 1'b1);
                chk("d_stream_data", in_d_data, 64'(i - 1));
            end
            step();
        end
        out_d_valid = 1'b0;
        chk("d_stream_done", in_d_valid, 1'b0);

        // Reset with beats queued on both paths
        out_a_ready = 1'b0; in_d_ready = 1'b0;
        in_a_valid = 1'b1; in_a_data = 64'haa; out_d_valid = 1'b1; out_d_data = 64'hbb;
        step(); step();
        in_a_valid = 1'b0; out_d_valid = 1'b0;
        chk("pre_rst_a_valid", out_a_valid, 1'b1);
        chk("pre_rst_d_valid", in_d_valid, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_a_valid", out_a_valid, 1'b0);
        chk("mid_rst_d_valid", in_d_valid, 1'b0);
        chk("mid_rst_a_ready", in_a_ready, 1'b1);
        chk("mid_rst_d_ready", out_d_ready, 1'b1);
        step();
        reset = 1'b1;
        out_a_ready = 1'b1; in_d_ready = 1'b1;
        step();
        chk("post_rst_a_lost", out_a_valid, 1'b0);
        chk("post_rst_d_lost", in_d_valid, 1'b0);

        // B/C/E pass-through with random values
        for (int i = 0; i < 8; i++) begin
            {out_b_valid, out_b_param, out_b_source} = 10'($urandom);
            out_b_address = $urandom;
            in_b_ready = 1'($urandom);
            {in_c_valid, in_c_opcode, in_c_param, in_c_size, in_c_source, in_c_corrupt} = 18'($urandom);
            in_c_address = $urandom;
            in_c_data = {$urandom, $urandom};
            out_c_ready = 1'($urandom);
            {in_e_valid, in_e_sink, out_e_ready} = 5'($urandom);
            #1;
            chk("bce_b_addr", in_b_address, out_b_address);
            chk("bce_c_data", out_c_data, in_c_data);
            chk("bce_e_sink", out_e_sink, in_e_sink);
            step();
        end

        step(); step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
